tftp_field_parse: RTL and testbench

//  Stage directly downstream of the TFTP opcode decoder in the rx path. Consumes
//  the same UDP-payload byte stream plus the decoder's ack/req flags, extracts the
//  ACK block number or the RRQ filename and mode, and emits one result pulse per frame.

---
 rtl/tftp_field_parse.sv | 218 +++++++++++++++++++++
 tb/tb_tftp_field_parse.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tftp_field_parse.sv
// TFTP field parser: sits after the opcode decoder, pulls the ACK block number or the
// RRQ filename/mode out of the payload and reports exactly one result pulse per frame.
module tftp_field_parse #(
  parameter int FNAME_MAX = 64,
  parameter int AW        = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic [7:0]    i_eth_data,
  input  logic          i_frame_end,
  input  logic          i_ack_op,
  input  logic          i_req_op,
  output logic [15:0]   o_block_num,
  output logic          o_ack_valid,
  output logic          o_req_valid,
  output logic          o_fname_wr_en,
  output logic [AW-1:0] o_fname_wr_addr,
  output logic [7:0]    o_fname_wr_data,
  output logic [AW:0]   o_fname_len,
  output logic          o_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DISPATCH = 3'd1,
    S_ACK_BLK  = 3'd2,
    S_FNAME    = 3'd3,
    S_MODE     = 3'd4,
    S_TAIL     = 3'd5,
    S_DROP     = 3'd6
  } state_t;

  localparam logic [AW:0] LP_FMAX = FNAME_MAX[AW:0];

  // Lower-case "octet", one character per mode index.
  function automatic logic [7:0] f_mode_char(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = 8'h6F;
      3'd1:    c = 8'h63;
      3'd2:    c = 8'h74;
      3'd3:    c = 8'h65;
      3'd4:    c = 8'h74;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [AW:0] r_len;
  logic [2:0]  r_midx;
  logic        r_mode_ok;

  // View of the parser state after absorbing this cycle's byte (if any).
  state_t      w_state;
  logic [2:0]  w_cnt;
  logic [AW:0] w_len;
  logic [2:0]  w_midx;
  logic        w_mode_ok;
  logic        w_wr;
  logic [AW-1:0] w_wr_addr;
  logic        w_blk_hi;
  logic        w_blk_lo;
  logic [7:0]  w_lc;
  logic        w_zero;
  logic        w_ack_done;
  logic        w_req_done;

  assign w_lc   = i_eth_data | 8'h20;
  assign w_zero = (i_eth_data == 8'h00);

  // Per-byte field extraction; frame_end is resolved afterwards on this result.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_len     = r_len;
    w_midx    = r_midx;
    w_mode_ok = r_mode_ok;
    w_wr      = 1'b0;
    w_wr_addr = r_len[AW-1:0];
    w_blk_hi  = 1'b0;
    w_blk_lo  = 1'b0;
    if (i_en) begin
      if (r_cnt != 3'd7) begin
        w_cnt = r_cnt + 3'd1;
      end else begin
        w_cnt = r_cnt;
      end
      case (r_state)
        S_IDLE: begin
          if (r_cnt == 3'd1) begin
            w_state = S_DISPATCH;
          end else begin
            w_state = S_IDLE;
          end
        end
        S_DISPATCH: begin
          if (i_ack_op) begin
            w_blk_hi = 1'b1;
            w_state  = S_ACK_BLK;
          end else if (i_req_op) begin
            // Byte 2 is already the first filename byte; an empty name is malformed.
            w_wr_addr = {AW{1'b0}};
            if (w_zero) begin
              w_len   = {(AW+1){1'b0}};
              w_state = S_DROP;
            end else begin
              w_wr    = 1'b1;
              w_len   = {{AW{1'b0}}, 1'b1};
              w_state = S_FNAME;
            end
          end else begin
            w_state = S_DROP;
          end
        end
        S_ACK_BLK: begin
          if (r_cnt == 3'd3) begin
            w_blk_lo = 1'b1;
          end else begin
            w_blk_lo = 1'b0;
          end
        end
        S_FNAME: begin
          if (w_zero) begin
            if (r_len == {(AW+1){1'b0}}) begin
              w_state = S_DROP;
            end else begin
              w_state   = S_MODE;
              w_midx    = 3'd0;
              w_mode_ok = 1'b1;
            end
          end else if (r_len == LP_FMAX) begin
            w_state = S_DROP;
          end else begin
            w_wr  = 1'b1;
            w_len = r_len + {{AW{1'b0}}, 1'b1};
          end
        end
        S_MODE: begin
          if (w_zero) begin
            w_state   = S_TAIL;
            w_mode_ok = r_mode_ok && (r_midx == 3'd5);
          end else begin
            if ((r_midx >= 3'd5) || (w_lc != f_mode_char(r_midx))) begin
              w_mode_ok = 1'b0;
            end else begin
              w_mode_ok = r_mode_ok;
            end
            if (r_midx != 3'd7) begin
              w_midx = r_midx + 3'd1;
            end else begin
              w_midx = r_midx;
            end
          end
        end
        S_TAIL:  w_state = S_TAIL;
        S_DROP:  w_state = S_DROP;
        default: w_state = S_DROP;
      endcase
    end else begin
      w_state = r_state;
    end
  end

  assign w_ack_done = (w_state == S_ACK_BLK) && (w_cnt >= 3'd4);
  assign w_req_done = (w_state == S_TAIL) && w_mode_ok;

  // Parser FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_cnt           <= 3'd0;
      r_len           <= {(AW+1){1'b0}};
      r_midx          <= 3'd0;
      r_mode_ok       <= 1'b0;
      o_block_num     <= 16'h0000;
      o_ack_valid     <= 1'b0;
      o_req_valid     <= 1'b0;
      o_err           <= 1'b0;
      o_fname_wr_en   <= 1'b0;
      o_fname_wr_addr <= {AW{1'b0}};
      o_fname_wr_data <= 8'h00;
      o_fname_len     <= {(AW+1){1'b0}};
    end else begin
      r_len         <= w_len;
      r_midx        <= w_midx;
      r_mode_ok     <= w_mode_ok;
      o_fname_len   <= w_len;
      o_fname_wr_en <= w_wr;
      if (w_wr) begin
        o_fname_wr_addr <= w_wr_addr;
        o_fname_wr_data <= i_eth_data;
      end
      if (w_blk_hi) begin
        o_block_num[15:8] <= i_eth_data;
      end
      if (w_blk_lo) begin
        o_block_num[7:0] <= i_eth_data;
      end
      if (i_frame_end) begin
        r_state     <= S_IDLE;
        r_cnt       <= 3'd0;
        o_ack_valid <= w_ack_done;
        o_req_valid <= w_req_done;
        o_err       <= !(w_ack_done || w_req_done);
      end else begin
        r_state     <= w_state;
        r_cnt       <= w_cnt;
        o_ack_valid <= 1'b0;
        o_req_valid <= 1'b0;
        o_err       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tftp_field_parse.sv
// Directed bench for tftp_field_parse: ACK/RRQ frames, malformed frames, overflow,
// mid-frame reset and back-to-back frames.
module tb_tftp_field_parse;

  localparam int FNAME_MAX = 64;
  localparam int AW        = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic [7:0]    eth_data = 8'h00;
  logic          frame_end = 1'b0;
  logic          ack_op = 1'b0;
  logic          req_op = 1'b0;
  logic [15:0]   o_block_num;
  logic          o_ack_valid;
  logic          o_req_valid;
  logic          o_fname_wr_en;
  logic [AW-1:0] o_fname_wr_addr;
  logic [7:0]    o_fname_wr_data;
  logic [AW:0]   o_fname_len;
  logic          o_err;

  tftp_field_parse #(.FNAME_MAX(FNAME_MAX), .AW(AW)) dut (
    .clk(clk), .reset(reset), .i_en(en), .i_eth_data(eth_data),
    .i_frame_end(frame_end), .i_ack_op(ack_op), .i_req_op(req_op),
    .o_block_num(o_block_num), .o_ack_valid(o_ack_valid), .o_req_valid(o_req_valid),
    .o_fname_wr_en(o_fname_wr_en), .o_fname_wr_addr(o_fname_wr_addr),
    .o_fname_wr_data(o_fname_wr_data), .o_fname_len(o_fname_len), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] frm [0:95];
  int         frm_len = 0;

  // Pulse/write monitor, sampled on the falling edge.
  int            n_ack = 0, n_req = 0, n_err = 0, n_wr = 0;
  logic [AW-1:0] wr_addr_log [0:255];
  logic [7:0]    wr_data_log [0:255];
  logic [15:0]   ack_blk_log [0:63];
  always @(negedge clk) begin
    if (o_ack_valid) begin
      if (n_ack < 64) ack_blk_log[n_ack] <= o_block_num;
      n_ack <= n_ack + 1;
    end
    if (o_req_valid) n_req <= n_req + 1;
    if (o_err) n_err <= n_err + 1;
    if (o_fname_wr_en && n_wr < 256) begin
      wr_addr_log[n_wr] <= o_fname_wr_addr;
      wr_data_log[n_wr] <= o_fname_wr_data;
      n_wr <= n_wr + 1;
    end
  end

  int b_ack, b_req, b_err, b_wr;

  task automatic snap();
    b_ack = n_ack; b_req = n_req; b_err = n_err; b_wr = n_wr;
  endtask

  task automatic frm_clear();
    frm_len = 0;
  endtask

  task automatic frm_add(input logic [7:0] b);
    frm[frm_len] = b;
    frm_len++;
  endtask

  task automatic frm_add_str(input string s);
    for (int i = 0; i < s.len(); i++) frm_add(s[i]);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; en = 1'b0; frame_end = 1'b0; ack_op = 1'b0; req_op = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  // Stream the frame buffer contiguously; the decoder flags appear from byte 2 on.
  task automatic send_frame(input bit fe_with_last);
    for (int i = 0; i < frm_len; i++) begin
      @(negedge clk);
      en = 1'b1;
      eth_data = frm[i];
      if (i >= 2) begin
        ack_op = (frm[0] == 8'h00) && (frm[1] == 8'h04);
        req_op = (frm[0] == 8'h00) && (frm[1] == 8'h01);
      end else begin
        ack_op = 1'b0;
        req_op = 1'b0;
      end
      frame_end = fe_with_last && (i == frm_len - 1);
    end
  endtask

  task automatic finish_frame(input bit need_fe);
    @(negedge clk);
    en = 1'b0; eth_data = 8'h00; ack_op = 1'b0; req_op = 1'b0; frame_end = need_fe;
    if (need_fe) begin
      @(negedge clk); frame_end = 1'b0;
    end
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
  endtask

  task automatic check_pulses(input string name, input int ea, input int er, input int ee);
    checks++;
    if ((n_ack - b_ack) !== ea || (n_req - b_req) !== er || (n_err - b_err) !== ee) begin
      errors++;
      $display("FAIL %s pulses: ack=%0d req=%0d err=%0d, expected ack=%0d req=%0d err=%0d",
               name, n_ack - b_ack, n_req - b_req, n_err - b_err, ea, er, ee);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({o_ack_valid, o_req_valid, o_err, o_fname_wr_en} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pulses: got %b expected 0000",
               {o_ack_valid, o_req_valid, o_err, o_fname_wr_en});
    end
    checks++;
    if (o_block_num !== 16'h0000 || o_fname_len !== 7'd0) begin
      errors++;
      $display("FAIL reset_regs: block_num=%h fname_len=%0d expected 0000 and 0", o_block_num, o_fname_len);
    end
  endtask

  task automatic test_ack();
    do_reset(); snap();
    frm_clear(); frm_add(8'h00); frm_add(8'h04); frm_add(8'h00); frm_add(8'h2A);
    send_frame(1'b0); finish_frame(1'b1); settle();
    check_pulses("ack", 1, 0, 0);
    checks++;
    if (o_block_num !== 16'h002A) begin
      errors++;
      $display("FAIL ack_block: got %h expected 002a", o_block_num);
    end
  endtask

  task automatic test_rrq();
    logic [7:0] exp_name [0:4];
    exp_name[0] = 8'h61; exp_name[1] = 8'h2E; exp_name[2] = 8'h62;
    exp_name[3] = 8'h69; exp_name[4] = 8'h6E;
    do_reset(); snap();
    frm_clear(); frm_add(8'h00); frm_add(8'h01); frm_add_str("a.bin"); frm_add(8'h00);
    frm_add_str("OCTET"); frm_add(8'h00);
    send_frame(1'b0); finish_frame(1'b1); settle();
    check_pulses("rrq", 0, 1, 0);
    checks++;
    if ((n_wr - b_wr) !== 5) begin
      errors++;
      $display("FAIL rrq_writes: got %0d expected 5", n_wr - b_wr);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wr_addr_log[b_wr + i] !== AW'(i) || wr_data_log[b_wr + i] !== exp_name[i]) begin
        errors++;
        $display("FAIL rrq_write%0d: addr=%0d data=%h expected addr=%0d data=%h",
                 i, wr_addr_log[b_wr + i], wr_data_log[b_wr + i], i, exp_name[i]);
      end
    end
    checks++;
    if (o_fname_len !== 7'd5) begin
      errors++;
      $display("FAIL rrq_len: got %0d expected 5", o_fname_len);
    end
  endtask

  task automatic test_bad_mode();
    string modes [0:2];
    modes[0] = "netascii"; modes[1] = "octets"; modes[2] = "oct";
    for (int m = 0; m < 3; m++) begin
      do_reset(); snap();
      frm_clear(); frm_add(8'h00); frm_add(8'h01); frm_add_str("f"); frm_add(8'h00);
      frm_add_str(modes[m]); frm_add(8'h00);
      send_frame(1'b0); finish_frame(1'b1); settle();
      check_pulses({"mode_", modes[m]}, 0, 0, 1);
    end
    // Mode never terminated.
    do_reset(); snap();
    frm_clear(); frm_add(8'h00); frm_add(8'h01); frm_add_str("f"); frm_add(8'h00);
    frm_add_str("octet");
    send_frame(1'b0); finish_frame(1'b1); settle();
    check_pulses("mode_unterminated", 0, 0, 1);
  endtask

  task automatic test_overflow();
    do_reset(); snap();
    frm_clear(); frm_add(8'h00); frm_add(8'h01);
    for (int i = 0; i < 65; i++) frm_add(8'h41 + 8'(i % 26));
    frm_add(8'h00); frm_add_str("octet"); frm_add(8'h00);
    send_frame(1'b0); finish_frame(1'b0); settle();
    check_pulses("overflow_before_end", 0, 0, 0);
    finish_frame(1'b1); settle();
    check_pulses("overflow", 0, 0, 1);
    checks++;
    if ((n_wr - b_wr) !== 64 || wr_addr_log[b_wr + 63] !== 6'd63 || wr_data_log[b_wr + 63] !== 8'h4C) begin
      errors++;
      $display("FAIL overflow_writes: count=%0d last addr=%0d data=%h expected 64, 63, 4c",
               n_wr - b_wr, wr_addr_log[b_wr + 63], wr_data_log[b_wr + 63]);
    end
    checks++;
    if (o_fname_len !== 7'd64) begin
      errors++;
      $display("FAIL overflow_len: got %0d expected 64", o_fname_len);
    end
  endtask

  task automatic test_malformed();
    do_reset(); snap();
    frm_clear(); frm_add(8'h00); frm_add(8'h04); frm_add(8'h00);
    send_frame(1'b0); finish_frame(1'b1); settle();
    check_pulses("ack_runt", 0, 0, 1);
    do_reset(); snap();
    frm_clear(); frm_add(8'h00); frm_add(8'h05); frm_add(8'h00); frm_add(8'h01);
    send_frame(1'b0); finish_frame(1'b1); settle();
    check_pulses("opcode_05", 0, 0, 1);
    do_reset(); snap();
    finish_frame(1'b1); settle();
    check_pulses("empty_frame", 0, 0, 1);
    do_reset(); snap();
    frm_clear(); frm_add(8'h00); frm_add(8'h01); frm_add(8'h00); frm_add_str("octet"); frm_add(8'h00);
    send_frame(1'b0); finish_frame(1'b1); settle();
    check_pulses("empty_name", 0, 0, 1);
    checks++;
    if ((n_wr - b_wr) !== 0) begin
      errors++;
      $display("FAIL empty_name_writes: got %0d expected 0", n_wr - b_wr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); snap();
    frm_clear(); frm_add(8'h00); frm_add(8'h01); frm_add_str("abc");
    send_frame(1'b0);
    @(negedge clk); en = 1'b0; ack_op = 1'b0; req_op = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    settle();
    check_pulses("reset_mid", 0, 0, 0);
    checks++;
    if (o_fname_len !== 7'd0) begin
      errors++;
      $display("FAIL reset_mid_len: got %0d expected 0", o_fname_len);
    end
    snap();
    frm_clear(); frm_add(8'h00); frm_add(8'h04); frm_add(8'h00); frm_add(8'h07);
    send_frame(1'b0); finish_frame(1'b1); settle();
    check_pulses("reset_mid_recover", 1, 0, 0);
    checks++;
    if (o_block_num !== 16'h0007) begin
      errors++;
      $display("FAIL reset_mid_block: got %h expected 0007", o_block_num);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(); snap();
    frm_clear(); frm_add(8'h00); frm_add(8'h04); frm_add(8'h12); frm_add(8'h34);
    send_frame(1'b1);
    frm_clear(); frm_add(8'h00); frm_add(8'h04); frm_add(8'hBE); frm_add(8'hEF);
    send_frame(1'b1);
    finish_frame(1'b0); settle();
    check_pulses("back_to_back", 2, 0, 0);
    checks++;
    if (ack_blk_log[b_ack] !== 16'h1234 || ack_blk_log[b_ack + 1] !== 16'hBEEF) begin
      errors++;
      $display("FAIL back_to_back_blocks: got %h,%h expected 1234,beef",
               ack_blk_log[b_ack], ack_blk_log[b_ack + 1]);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_ack();
    test_rrq();
    test_bad_mode();
    test_overflow();
    test_malformed();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
